// File: rtl/mixer_sequencer_pkg.sv
// Shared types and constants for the mixer sample sequencer.
// Imported by the sequencer top and its wait timer.
package mixer_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_IN_REQ,
    SEQ_PIPE_WAIT,
    SEQ_OUT_REQ,
    SEQ_EMIT
  } seq_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int OVERRUN_WIDTH = 8;

endpackage

// File: rtl/mixer_sequencer_wait_timer.sv
// Wait-state watchdog: counts enabled cycles since the last clear
// and holds expired once the terminal count is reached.
module wait_timer
  import mixer_sequencer_pkg::*;
#(
  parameter int timeout_cycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(timeout_cycles + 1);
  localparam logic [W-1:0] TERM = W'(timeout_cycles);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TERM);

endmodule

// File: rtl/mixer_sequencer.sv
// Codec-side scheduler for the mixer: input gain, effect pipelines,
// crossfade/output gain, DAC emit, with overrun and stall recovery.
module mixer_sequencer
  import mixer_sequencer_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int timeout_cycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [data_width-1:0]    adc_sample,
  output logic [data_width-1:0]    dac_sample,
  output logic                     dac_sample_valid,
  output logic [data_width-1:0]    mix_in_sample,
  output logic                     mix_in_valid,
  input  logic                     mix_in_ready,
  input  logic [data_width-1:0]    mix_in_gained,
  output logic [data_width-1:0]    pipe_sample,
  output logic                     pipe_sample_valid,
  input  logic [data_width-1:0]    pipe_a_sample,
  input  logic [data_width-1:0]    pipe_b_sample,
  input  logic                     pipe_a_ready,
  input  logic                     pipe_b_ready,
  output logic [data_width-1:0]    mix_out_a,
  output logic [data_width-1:0]    mix_out_b,
  output logic                     mix_out_valid,
  input  logic                     mix_out_ready,
  input  logic [data_width-1:0]    mix_out_sample,
  output logic [OVERRUN_WIDTH-1:0] overrun_count,
  output logic                     timeout_flag
);

  typedef logic [data_width-1:0] smp_t;

  seq_state_t state, state_n;

  smp_t dac_n, in_smp_n, pipe_n;
  smp_t out_a_n, out_b_n;
  smp_t a_lat, b_lat, a_lat_n, b_lat_n;
  smp_t a_val, b_val;
  logic a_got, b_got, a_got_n, b_got_n;
  logic a_hit, b_hit;
  logic dac_v_n, in_v_n, pipe_v_n, out_v_n;
  logic tflag_n;
  logic [OVERRUN_WIDTH-1:0] ovr_n;

  logic t_clear, t_enable, expired;

  assign t_clear  = (state_n != state);
  assign t_enable = (state == SEQ_IN_REQ)
                 || (state == SEQ_PIPE_WAIT)
                 || (state == SEQ_OUT_REQ);

  wait_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clear),
    .enable (t_enable),
    .expired(expired)
  );

  // A pulse in the current cycle counts as received immediately.
  assign a_hit = a_got | pipe_a_ready;
  assign b_hit = b_got | pipe_b_ready;
  assign a_val = pipe_a_ready ? pipe_a_sample : a_lat;
  assign b_val = pipe_b_ready ? pipe_b_sample : b_lat;

  always_comb begin
    state_n  = state;
    dac_n    = dac_sample;
    dac_v_n  = 1'b0;
    in_smp_n = mix_in_sample;
    in_v_n   = mix_in_valid;
    pipe_n   = pipe_sample;
    pipe_v_n = 1'b0;
    out_a_n  = mix_out_a;
    out_b_n  = mix_out_b;
    out_v_n  = mix_out_valid;
    a_lat_n  = a_lat;
    b_lat_n  = b_lat;
    a_got_n  = a_got;
    b_got_n  = b_got;
    tflag_n  = timeout_flag;
    ovr_n    = overrun_count;

    unique case (state)
      SEQ_IDLE: begin
        if (sample_tick) begin
          in_smp_n = adc_sample;
          in_v_n   = 1'b1;
          state_n  = SEQ_IN_REQ;
        end
      end
      SEQ_IN_REQ: begin
        if (mix_in_ready) begin
          in_v_n   = 1'b0;
          pipe_n   = mix_in_gained;
          pipe_v_n = 1'b1;
          a_got_n  = 1'b0;
          b_got_n  = 1'b0;
          state_n  = SEQ_PIPE_WAIT;
        end else if (expired) begin
          in_v_n   = 1'b0;
          tflag_n  = 1'b1;
          dac_v_n  = 1'b1;
          state_n  = SEQ_EMIT;
        end
      end
      SEQ_PIPE_WAIT: begin
        a_lat_n = a_val;
        b_lat_n = b_val;
        a_got_n = a_hit;
        b_got_n = b_hit;
        if ((a_hit && b_hit) || expired) begin
          out_a_n = a_hit ? a_val : '0;
          out_b_n = b_hit ? b_val : '0;
          out_v_n = 1'b1;
          state_n = SEQ_OUT_REQ;
          if (!(a_hit && b_hit)) tflag_n = 1'b1;
        end
      end
      SEQ_OUT_REQ: begin
        if (mix_out_ready) begin
          out_v_n = 1'b0;
          dac_n   = mix_out_sample;
          dac_v_n = 1'b1;
          state_n = SEQ_EMIT;
        end else if (expired) begin
          out_v_n = 1'b0;
          tflag_n = 1'b1;
          dac_v_n = 1'b1;
          state_n = SEQ_EMIT;
        end
      end
      SEQ_EMIT: begin
        state_n = SEQ_IDLE;
      end
      default: begin
        state_n = SEQ_IDLE;
      end
    endcase

    if (sample_tick && state != SEQ_IDLE
        && overrun_count != '1) begin
      ovr_n = overrun_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= SEQ_IDLE;
      dac_sample        <= '0;
      dac_sample_valid  <= 1'b0;
      mix_in_sample     <= '0;
      mix_in_valid      <= 1'b0;
      pipe_sample       <= '0;
      pipe_sample_valid <= 1'b0;
      mix_out_a         <= '0;
      mix_out_b         <= '0;
      mix_out_valid     <= 1'b0;
      a_lat             <= '0;
      b_lat             <= '0;
      a_got             <= 1'b0;
      b_got             <= 1'b0;
      overrun_count     <= '0;
      timeout_flag      <= 1'b0;
    end else begin
      state             <= state_n;
      dac_sample        <= dac_n;
      dac_sample_valid  <= dac_v_n;
      mix_in_sample     <= in_smp_n;
      mix_in_valid      <= in_v_n;
      pipe_sample       <= pipe_n;
      pipe_sample_valid <= pipe_v_n;
      mix_out_a         <= out_a_n;
      mix_out_b         <= out_b_n;
      mix_out_valid     <= out_v_n;
      a_lat             <= a_lat_n;
      b_lat             <= b_lat_n;
      a_got             <= a_got_n;
      b_got             <= b_got_n;
      overrun_count     <= ovr_n;
      timeout_flag      <= tflag_n;
    end
  end

endmodule

// File: tb/tb_mixer_sequencer.sv
// Bench for mixer_sequencer: mixer and pipeline models plus a
// drive-time scoreboard checked by an output monitor.
module tb_mixer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [15:0] adc_sample = '0;
  logic [15:0] dac_sample;
  logic        dac_sample_valid;
  logic [15:0] mix_in_sample;
  logic        mix_in_valid;
  logic        mix_in_ready = 1'b0;
  logic [15:0] mix_in_gained = '0;
  logic [15:0] pipe_sample;
  logic        pipe_sample_valid;
  logic [15:0] pipe_a_sample = '0;
  logic [15:0] pipe_b_sample = '0;
  logic        pipe_a_ready = 1'b0;
  logic        pipe_b_ready = 1'b0;
  logic [15:0] mix_out_a;
  logic [15:0] mix_out_b;
  logic        mix_out_valid;
  logic        mix_out_ready = 1'b0;
  logic [15:0] mix_out_sample = '0;
  logic [7:0]  overrun_count;
  logic        timeout_flag;

  mixer_sequencer #(
    .data_width    (16),
    .timeout_cycles(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_tick      (sample_tick),
    .adc_sample       (adc_sample),
    .dac_sample       (dac_sample),
    .dac_sample_valid (dac_sample_valid),
    .mix_in_sample    (mix_in_sample),
    .mix_in_valid     (mix_in_valid),
    .mix_in_ready     (mix_in_ready),
    .mix_in_gained    (mix_in_gained),
    .pipe_sample      (pipe_sample),
    .pipe_sample_valid(pipe_sample_valid),
    .pipe_a_sample    (pipe_a_sample),
    .pipe_b_sample    (pipe_b_sample),
    .pipe_a_ready     (pipe_a_ready),
    .pipe_b_ready     (pipe_b_ready),
    .mix_out_a        (mix_out_a),
    .mix_out_b        (mix_out_b),
    .mix_out_valid    (mix_out_valid),
    .mix_out_ready    (mix_out_ready),
    .mix_out_sample   (mix_out_sample),
    .overrun_count    (overrun_count),
    .timeout_flag     (timeout_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Environment behaviour
  bit pipe_xform = 1'b0;
  int a_delay = 3;
  int b_delay = 3;
  bit in_en = 1'b1;
  bit out_en = 1'b1;
  bit out_pulse_req = 1'b0;

  function automatic logic [15:0] gain(input logic [15:0] x);
    return 16'($signed(x) >>> 4);
  endfunction

  function automatic logic [15:0] fa(input logic [15:0] g);
    return pipe_xform ? g + 16'd1 : g;
  endfunction

  function automatic logic [15:0] fb(input logic [15:0] g);
    return pipe_xform ? (g ^ 16'h00f0) : g;
  endfunction

  function automatic logic [15:0] mixout(input logic [15:0] a,
                                         input logic [15:0] b);
    return 16'(($signed(a) >>> 1) + ($signed(b) >>> 1));
  endfunction

  int in_cnt = 0;
  initial forever begin
    @(negedge clk);
    mix_in_ready = 1'b0;
    if (reset || !mix_in_valid) begin
      in_cnt = 0;
    end else if (in_en) begin
      in_cnt++;
      if (in_cnt == 5) begin
        mix_in_ready  = 1'b1;
        mix_in_gained = gain(mix_in_sample);
        in_cnt = 0;
      end
    end
  end

  int out_cnt = 0;
  initial forever begin
    @(negedge clk);
    mix_out_ready = 1'b0;
    if (out_pulse_req) begin
      mix_out_ready  = 1'b1;
      mix_out_sample = 16'h7777;
      out_pulse_req  = 1'b0;
    end else if (reset || !mix_out_valid) begin
      out_cnt = 0;
    end else if (out_en) begin
      out_cnt++;
      if (out_cnt == 8) begin
        mix_out_ready  = 1'b1;
        mix_out_sample = mixout(mix_out_a, mix_out_b);
        out_cnt = 0;
      end
    end
  end

  int ca = 0;
  int cb = 0;
  logic [15:0] pg = '0;
  initial forever begin
    @(negedge clk);
    pipe_a_ready = 1'b0;
    pipe_b_ready = 1'b0;
    if (reset) begin
      ca = 0;
      cb = 0;
    end else if (pipe_sample_valid) begin
      pg = pipe_sample;
      ca = a_delay;
      cb = b_delay;
    end else begin
      if (ca > 0) begin
        ca--;
        if (ca == 0) begin
          pipe_a_ready  = 1'b1;
          pipe_a_sample = fa(pg);
        end
      end
      if (cb > 0) begin
        cb--;
        if (cb == 0) begin
          pipe_b_ready  = 1'b1;
          pipe_b_sample = fb(pg);
        end
      end
    end
  end

  // Scoreboard
  logic [15:0] q_pipe[$];
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_dac[$];

  bit sat_mode = 1'b0;
  logic [15:0] sat_g, sat_a, sat_b, sat_d;
  int sat_frames = 0;

  task automatic push_frame(input logic [15:0] x);
    logic [15:0] g, a, b;
    g = gain(x);
    a = (a_delay == 0) ? 16'h0 : fa(g);
    b = (b_delay == 0) ? 16'h0 : fb(g);
    q_pipe.push_back(g);
    q_a.push_back(a);
    q_b.push_back(b);
    q_dac.push_back(mixout(a, b));
  endtask

  int cyc = 0;
  int last_rdy = 0;
  bit lat_chk = 1'b0;
  logic mov_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (pipe_a_ready || pipe_b_ready) last_rdy = cyc;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      if (pipe_sample_valid) begin
        if (sat_mode)
          chk("sat_pipe", 32'(pipe_sample), 32'(sat_g));
        else if (q_pipe.size() == 0)
          chk("pipe_extra", 32'd1, 32'd0);
        else
          chk("pipe", 32'(pipe_sample), 32'(q_pipe.pop_front()));
      end
      if (mix_out_valid && !mov_prev) begin
        if (sat_mode) begin
          chk("sat_a", 32'(mix_out_a), 32'(sat_a));
          chk("sat_b", 32'(mix_out_b), 32'(sat_b));
        end else if (q_a.size() == 0) begin
          chk("mix_extra", 32'd1, 32'd0);
        end else begin
          chk("mix_a", 32'(mix_out_a), 32'(q_a.pop_front()));
          chk("mix_b", 32'(mix_out_b), 32'(q_b.pop_front()));
        end
        if (lat_chk)
          chk("mov_lat", 32'(cyc - last_rdy), 32'd1);
      end
      if (dac_sample_valid) begin
        if (sat_mode) begin
          sat_frames++;
          chk("sat_dac", 32'(dac_sample), 32'(sat_d));
        end else if (q_dac.size() == 0)
          chk("dac_extra", 32'd1, 32'd0);
        else
          chk("dac", 32'(dac_sample), 32'(q_dac.pop_front()));
      end
    end
    mov_prev = mix_out_valid;
  end

  task automatic tick(input logic [15:0] x, input bit push);
    @(negedge clk);
    sample_tick = 1'b1;
    adc_sample  = x;
    if (push) push_frame(x);
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q_dac.size() != 0 || q_a.size() != 0
            || q_pipe.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(q_dac.size() + q_a.size() + q_pipe.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dac"},  32'(dac_sample), 32'd0);
    chk({tag, "_dacv"}, 32'(dac_sample_valid), 32'd0);
    chk({tag, "_inv"},  32'(mix_in_valid), 32'd0);
    chk({tag, "_ins"},  32'(mix_in_sample), 32'd0);
    chk({tag, "_pipe"}, 32'(pipe_sample), 32'd0);
    chk({tag, "_outa"}, 32'(mix_out_a), 32'd0);
    chk({tag, "_outb"}, 32'(mix_out_b), 32'd0);
    chk({tag, "_outv"}, 32'(mix_out_valid), 32'd0);
    chk({tag, "_ovr"},  32'(overrun_count), 32'd0);
    chk({tag, "_tmo"},  32'(timeout_flag), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // Basic frame with echoing pipelines
    pipe_xform = 1'b0;
    tick(16'h1234, 1'b1);
    drain("basic");
    chk("basic_ovr", 32'(overrun_count), 32'd0);
    chk("basic_tmo", 32'(timeout_flag), 32'd0);

    // B ten cycles ahead of A, then both together
    pipe_xform = 1'b1;
    lat_chk = 1'b1;
    a_delay = 13;
    b_delay = 3;
    tick(16'h5a50, 1'b1);
    drain("order_ba");
    a_delay = 4;
    b_delay = 4;
    tick(16'h8f00, 1'b1);
    drain("order_same");
    chk("order_tmo", 32'(timeout_flag), 32'd0);
    lat_chk = 1'b0;

    // Pipeline B silent
    a_delay = 2;
    b_delay = 0;
    tick(16'h0c40, 1'b1);
    drain("pipe_tmo");
    chk("pipe_tmo_flag", 32'(timeout_flag), 32'd1);

    // Ticks every five cycles during a frame
    a_delay = 3;
    b_delay = 3;
    tick(16'h1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      tick(16'hdead + 16'(i), 1'b0);
    end
    drain("ovr");
    chk("ovr_cnt", 32'(overrun_count), 32'd3);

    // Continuous ticks saturate the overrun counter
    adc_sample = 16'h0400;
    sat_g = gain(16'h0400);
    sat_a = fa(sat_g);
    sat_b = fb(sat_g);
    sat_d = mixout(sat_a, sat_b);
    sat_mode = 1'b1;
    @(negedge clk);
    sample_tick = 1'b1;
    repeat (400) @(negedge clk);
    sample_tick = 1'b0;
    repeat (80) @(negedge clk);
    sat_mode = 1'b0;
    chk("sat_ovr", 32'(overrun_count), 32'd255);
    chk("sat_frames", 32'(sat_frames > 5), 32'd1);

    // Reset while waiting on the output mixer
    out_en = 1'b0;
    tick(16'h2222, 1'b1);
    n = 0;
    while (!mix_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait", 32'(mix_out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    q_dac.delete();
    q_a.delete();
    q_pipe.delete();
    out_pulse_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("late_dac", 32'(dac_sample), 32'd0);
    chk("late_outv", 32'(mix_out_valid), 32'd0);
    out_en = 1'b1;
    tick(16'h0800, 1'b1);
    drain("post_rst");
    chk("post_rst_ovr", 32'(overrun_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
